// File: rtl/shared_llq_fifo_pkg.sv
// Shared defaults and types for the linked-list shared FIFO.
// Optional per-FIFO occupancy counters are enabled with `define LLQ_COUNT_EN.
package shared_llq_fifo_pkg;

    localparam int unsigned LLQ_WIDTH     = 8;
    localparam int unsigned LLQ_DEPTH     = 8;
    localparam int unsigned LLQ_NUM_FIFOS = 4;

    // Free-list operation encoding: {release, alloc}
    typedef enum logic [1:0] {
        FL_IDLE    = 2'b00,
        FL_ALLOC   = 2'b01,
        FL_RELEASE = 2'b10,
        FL_BOTH    = 2'b11
    } fl_op_e;

    // Low bit of FIFO idx's field inside the flattened count bus.
    function automatic int unsigned cnt_lo(input int unsigned idx, input int unsigned cw);
        return idx * cw;
    endfunction

endpackage

// File: rtl/shared_llq_fifo_free_list.sv
// Free list of shared entries: head/tail/next links, free count and registered full.
module shared_llq_fifo_free_list
    import shared_llq_fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = LLQ_DEPTH,
    parameter int unsigned PTR_WIDTH = $clog2(DEPTH),
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc,
    input  logic                 rel,
    input  logic [PTR_WIDTH-1:0] rel_ptr,
    output logic [PTR_WIDTH-1:0] alloc_ptr,
    output logic                 full
);

    logic [PTR_WIDTH-1:0] head;
    logic [PTR_WIDTH-1:0] tail;
    logic [PTR_WIDTH-1:0] nxt [DEPTH];
    logic [CNT_WIDTH-1:0] free_cnt;
    logic [CNT_WIDTH-1:0] free_cnt_next;
    fl_op_e               op;

    assign op        = fl_op_e'({rel, alloc});
    assign alloc_ptr = head;

    always_comb begin
        free_cnt_next = free_cnt;
        case (op)
            FL_ALLOC:   free_cnt_next = free_cnt - CNT_WIDTH'(1);
            FL_RELEASE: free_cnt_next = free_cnt + CNT_WIDTH'(1);
            default:    free_cnt_next = free_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= PTR_WIDTH'(DEPTH - 1);
            free_cnt <= CNT_WIDTH'(DEPTH);
            full     <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                nxt[i] <= PTR_WIDTH'((i + 1) % DEPTH);
            end
        end else begin
            free_cnt <= free_cnt_next;
            full     <= (free_cnt_next == '0);
            case (op)
                FL_ALLOC: head <= nxt[head];
                FL_RELEASE: begin
                    if (free_cnt == '0) head <= rel_ptr;
                    else                nxt[tail] <= rel_ptr;
                    tail <= rel_ptr;
                end
                FL_BOTH: begin
                    // Last free entry is consumed while the released one becomes the sole free entry
                    if (free_cnt == CNT_WIDTH'(1)) begin
                        head <= rel_ptr;
                    end else begin
                        head      <= nxt[head];
                        nxt[tail] <= rel_ptr;
                    end
                    tail <= rel_ptr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/shared_llq_fifo.sv
// NUM_FIFOS linked-list FIFOs sharing one DEPTH-entry memory; one push and one pop per cycle.
// Define LLQ_COUNT_EN to add per-FIFO occupancy registers on the count port.
module shared_llq_fifo
    import shared_llq_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = LLQ_WIDTH,
    parameter int unsigned DEPTH     = LLQ_DEPTH,
    parameter int unsigned NUM_FIFOS = LLQ_NUM_FIFOS,
    parameter int unsigned PTR_WIDTH = $clog2(DEPTH),
    parameter int unsigned SEL_WIDTH = $clog2(NUM_FIFOS),
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [SEL_WIDTH-1:0] push_sel,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 pop,
    input  logic [SEL_WIDTH-1:0] pop_sel,
    output logic                 full,
    output logic [NUM_FIFOS-1:0] empty,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_valid,
    output logic                 err
`ifdef LLQ_COUNT_EN
    ,
    output logic [NUM_FIFOS*CNT_WIDTH-1:0] count
`endif
);

    logic [WIDTH-1:0]     mem  [DEPTH];
    logic [PTR_WIDTH-1:0] link [DEPTH];
    logic [PTR_WIDTH-1:0] head [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] tail [NUM_FIFOS];

    logic                 push_ok;
    logic                 pop_ok;
    logic                 same_last;
    logic [PTR_WIDTH-1:0] alloc_ptr;
    logic [PTR_WIDTH-1:0] pop_ptr;

    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty[pop_sel];
    assign pop_ptr   = head[pop_sel];
    // Push lands on a FIFO whose only entry is leaving this cycle
    assign same_last = pop_ok & (pop_sel == push_sel) & (head[push_sel] == tail[push_sel]);

    shared_llq_fifo_free_list #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .alloc     (push_ok),
        .rel       (pop_ok),
        .rel_ptr   (pop_ptr),
        .alloc_ptr (alloc_ptr),
        .full      (full)
    );

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[alloc_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok && !empty[push_sel] && !same_last) link[tail[push_sel]] <= alloc_ptr;
    end

    // empty doubles as the inverted head-valid flag of each list
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
            empty      <= '1;
            for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
            end
        end else begin
            err        <= (push & full) | (pop & empty[pop_sel]);
            data_valid <= pop_ok;
            if (pop_ok) data_out <= mem[pop_ptr];
            for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
                if (pop_ok && pop_sel == SEL_WIDTH'(i)) begin
                    if (head[i] == tail[i]) begin
                        if (push_ok && push_sel == SEL_WIDTH'(i)) begin
                            head[i] <= alloc_ptr;
                            tail[i] <= alloc_ptr;
                        end else begin
                            empty[i] <= 1'b1;
                        end
                    end else begin
                        head[i] <= link[head[i]];
                        if (push_ok && push_sel == SEL_WIDTH'(i)) tail[i] <= alloc_ptr;
                    end
                end else if (push_ok && push_sel == SEL_WIDTH'(i)) begin
                    tail[i] <= alloc_ptr;
                    if (empty[i]) begin
                        head[i]  <= alloc_ptr;
                        empty[i] <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef LLQ_COUNT_EN
    logic [CNT_WIDTH-1:0] occ [NUM_FIFOS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_FIFOS; i++) occ[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
                case ({push_ok && push_sel == SEL_WIDTH'(i), pop_ok && pop_sel == SEL_WIDTH'(i)})
                    2'b10:   occ[i] <= occ[i] + CNT_WIDTH'(1);
                    2'b01:   occ[i] <= occ[i] - CNT_WIDTH'(1);
                    default: occ[i] <= occ[i];
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_count
        assign count[cnt_lo(g, CNT_WIDTH) +: CNT_WIDTH] = occ[g];
    end
`endif

endmodule
